// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt sequencer.
//   irq_state_e        : sequencer state encoding
//   ISR_VECTOR_DEFAULT : default ISR entry byte address
//   ADDR_W / CNT_W     : address width and drain-counter width
package irq_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [ADDR_W-1:0] ISR_VECTOR_DEFAULT = 32'h0000_0100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        ENTER  = 3'd2,
        ISR    = 3'd3,
        RETURN = 3'd4
    } irq_state_e;

endpackage : irq_pkg

// File: rtl/irq_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level input followed by a
// rising-edge detector.
//   clk, rst_n : clock and synchronous active-low reset
//   async_in   : asynchronous level input
//   rise_c     : one-cycle pulse (combinational from flops) on a synchronized 0->1
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus the previous-value flop used for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : irq_sync_edge

// File: rtl/irq_ctrl.sv
// Interrupt sequencer in front of the program counter. Synchronizes irq,
// drains the pipeline with int_nop, redirects fetch to the ISR vector, keeps
// the return PC (epc) and performs the ERET jump back.
//   clk, rst_n  : clock and synchronous active-low reset
//   irq         : asynchronous interrupt request (rising edge is the event)
//   pc          : current fetch PC
//   jp_success  : branch/jump taken this cycle, jp_target its destination
//   load_use    : load-use stall active
//   eret_id     : ERET decoded this cycle
//   int_nop     : hold PC and inject NOP
//   irq_enter   : pulse, load pc_target (ISR vector) into PC
//   irq_ret     : pulse, load pc_target (epc) into PC
//   pc_target   : redirect address
//   epc         : saved return address
//   in_isr      : high from irq_enter through the irq_ret cycle
module irq_ctrl
    import irq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ISR_VECTOR   = ISR_VECTOR_DEFAULT,
    parameter int unsigned       DRAIN_CYCLES = 2,
    parameter int unsigned       SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              irq,
    input  logic [ADDR_W-1:0] pc,
    input  logic              jp_success,
    input  logic [ADDR_W-1:0] jp_target,
    input  logic              load_use,
    input  logic              eret_id,
    output logic              int_nop,
    output logic              irq_enter,
    output logic              irq_ret,
    output logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] epc,
    output logic              in_isr
);

    irq_state_e        state_q, state_d;
    logic              pending_q, pending_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] epc_d;
    logic [ADDR_W-1:0] pc_target_d;
    logic              int_nop_d, irq_enter_d, irq_ret_d, in_isr_d;
    logic              irq_rise_c;

    // Input conditioning for the external request.
    irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (irq),
        .rise_c   (irq_rise_c)
    );

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            epc       <= '0;
            pc_target <= '0;
            int_nop   <= 1'b0;
            irq_enter <= 1'b0;
            irq_ret   <= 1'b0;
            in_isr    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            epc       <= epc_d;
            pc_target <= pc_target_d;
            int_nop   <= int_nop_d;
            irq_enter <= irq_enter_d;
            irq_ret   <= irq_ret_d;
            in_isr    <= in_isr_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they are
    // valid in the same cycle the state register holds that state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        epc_d     = epc;
        // Edges merge into a single pending request.
        pending_d = pending_q | irq_rise_c;

        case (state_q)
            IDLE: begin
                // A taken branch or load-use stall defers entry so epc is stable.
                if (pending_q && !jp_success && !load_use) begin
                    state_d = DRAIN;
                    epc_d   = pc;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                // An older branch resolving during drain is the true return point.
                if (jp_success) begin
                    epc_d = jp_target;
                end
                if (cnt_q == '0) begin
                    state_d = ENTER;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ENTER: begin
                state_d   = ISR;
                // Request being serviced is retired; a coincident new edge survives.
                pending_d = irq_rise_c;
            end
            ISR: begin
                if (eret_id) begin
                    state_d = RETURN;
                end
            end
            RETURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        int_nop_d   = (state_d == DRAIN);
        irq_enter_d = (state_d == ENTER);
        irq_ret_d   = (state_d == RETURN);
        in_isr_d    = (state_d == ENTER) || (state_d == ISR) || (state_d == RETURN);
        pc_target_d = (state_d == ENTER) ? ISR_VECTOR : epc_d;
    end

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with default parameters.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq;
    logic [31:0] pc;
    logic        jp_success;
    logic [31:0] jp_target;
    logic        load_use;
    logic        eret_id;
    logic        int_nop;
    logic        irq_enter;
    logic        irq_ret;
    logic [31:0] pc_target;
    logic [31:0] epc;
    logic        in_isr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq        (irq),
        .pc         (pc),
        .jp_success (jp_success),
        .jp_target  (jp_target),
        .load_use   (load_use),
        .eret_id    (eret_id),
        .int_nop    (int_nop),
        .irq_enter  (irq_enter),
        .irq_ret    (irq_ret),
        .pc_target  (pc_target),
        .epc        (epc),
        .in_isr     (in_isr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise irq long enough to be synchronized, then drop it; leaves the
    // bench 3 cycles after the rise, when pending has just been set.
    task automatic pulse_irq();
        irq = 1'b1;
        tick(3);
        irq = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        irq        = 1'b0;
        pc         = 32'h40;
        jp_success = 1'b0;
        jp_target  = 32'h0;
        load_use   = 1'b0;
        eret_id    = 1'b0;

        // Reset state
        tick(2);
        chk("rst_int_nop",   int_nop,   0);
        chk("rst_irq_enter", irq_enter, 0);
        chk("rst_irq_ret",   irq_ret,   0);
        chk("rst_in_isr",    in_isr,    0);
        chk("rst_epc",       epc,       0);
        chk("rst_pc_target", pc_target, 0);
        rst_n = 1'b1;
        tick(1);

        // Basic entry / return: int_nop 4 cycles after edge, 2 cycles long
        pulse_irq();
        chk("b_nop_early", int_nop, 0);
        tick(1);
        chk("b_nop1", int_nop, 1);
        chk("b_epc",  epc,     32'h40);
        tick(1);
        chk("b_nop2",   int_nop,   1);
        chk("b_enter0", irq_enter, 0);
        tick(1);
        chk("b_enter",    irq_enter, 1);
        chk("b_vec",      pc_target, 32'h100);
        chk("b_nop_off",  int_nop,   0);
        chk("b_isr",      in_isr,    1);
        tick(1);
        chk("b_enter_pulse", irq_enter, 0);
        chk("b_isr_hold",    in_isr,    1);
        chk("b_tgt_epc",     pc_target, 32'h40);
        tick(2);
        eret_id = 1'b1;
        tick(1);
        eret_id = 1'b0;
        chk("b_ret",       irq_ret,   1);
        chk("b_ret_tgt",   pc_target, 32'h40);
        chk("b_ret_isr",   in_isr,    1);
        chk("b_ret_enter", irq_enter, 0);
        tick(1);
        chk("b_ret_pulse", irq_ret, 0);
        chk("b_isr_drop",  in_isr,  0);

        // Branch blocking: entry deferred while jp_success is high
        pc = 32'h60;
        pulse_irq();
        jp_success = 1'b1;
        jp_target  = 32'h80;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("br_blocked", int_nop, 0);
        end
        jp_success = 1'b0;
        pc         = 32'h80;
        tick(1);
        chk("br_nop", int_nop, 1);
        chk("br_epc", epc,     32'h80);
        tick(2);
        chk("br_enter", irq_enter, 1);
        tick(1);
        eret_id = 1'b1;
        tick(1);
        eret_id = 1'b0;
        chk("br_ret",     irq_ret,   1);
        chk("br_ret_tgt", pc_target, 32'h80);
        tick(1);

        // Branch during drain (with load_use, which must not stall the counter)
        pc = 32'h40;
        pulse_irq();
        tick(1);
        chk("dr_nop", int_nop, 1);
        chk("dr_epc0", epc, 32'h40);
        jp_success = 1'b1;
        jp_target  = 32'hA0;
        load_use   = 1'b1;
        tick(1);
        jp_success = 1'b0;
        load_use   = 1'b0;
        chk("dr_epc1", epc,     32'hA0);
        chk("dr_nop2", int_nop, 1);
        tick(1);
        chk("dr_enter", irq_enter, 1);
        chk("dr_vec",   pc_target, 32'h100);
        chk("dr_epc2",  epc,       32'hA0);
        tick(1);

        // Nested request: three edges inside the ISR, one extra entry
        for (int k = 0; k < 3; k++) begin
            pulse_irq();
            chk("ns_no_nest_a", int_nop, 0);
            tick(3);
            chk("ns_no_nest_b", int_nop, 0);
            chk("ns_in_isr",    in_isr,  1);
        end
        eret_id = 1'b1;
        tick(1);
        eret_id = 1'b0;
        chk("ns_ret",     irq_ret,   1);
        chk("ns_ret_tgt", pc_target, 32'hA0);
        chk("ns_ret_nop", int_nop,   0);
        tick(1);
        chk("ns_idle_nop", int_nop, 0);
        chk("ns_idle_isr", in_isr,  0);
        tick(1);
        chk("ns_drain", int_nop, 1);
        chk("ns_epc",   epc,     32'h40);
        tick(2);
        chk("ns_enter", irq_enter, 1);
        tick(1);
        eret_id = 1'b1;
        tick(1);
        eret_id = 1'b0;
        chk("ns_ret2",     irq_ret,   1);
        chk("ns_ret2_tgt", pc_target, 32'h40);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("ns_single_nop",   int_nop,   0);
            chk("ns_single_enter", irq_enter, 0);
        end

        // Stray ERET in IDLE
        eret_id = 1'b1;
        tick(1);
        eret_id = 1'b0;
        chk("se_ret", irq_ret, 0);
        chk("se_isr", in_isr,  0);
        tick(1);
        chk("se_nop", int_nop, 0);

        // Load-use in IDLE defers entry by one cycle
        pulse_irq();
        load_use = 1'b1;
        tick(1);
        load_use = 1'b0;
        chk("lu_blocked", int_nop, 0);
        tick(1);
        chk("lu_nop", int_nop, 1);
        tick(2);
        chk("lu_enter", irq_enter, 1);
        tick(1);
        eret_id = 1'b1;
        tick(1);
        eret_id = 1'b0;
        chk("lu_ret", irq_ret, 1);
        tick(1);

        // Reset mid-drain: everything cleared, pending lost
        pc = 32'h44;
        pulse_irq();
        tick(1);
        chk("rd_nop", int_nop, 1);
        chk("rd_epc", epc,     32'h44);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("rd_int_nop",   int_nop,   0);
        chk("rd_irq_enter", irq_enter, 0);
        chk("rd_irq_ret",   irq_ret,   0);
        chk("rd_in_isr",    in_isr,    0);
        chk("rd_epc0",      epc,       0);
        chk("rd_pc_target", pc_target, 0);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("rd_no_enter", irq_enter, 0);
            chk("rd_no_nop",   int_nop,   0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_irq_ctrl

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt sequencer that sits directly upstream of the program counter.
- Detects external interrupt requests and freezes fetch while the pipeline drains.
- Redirects fetch to the ISR vector, saves the return PC (EPC), and handles the ERET return jump.
- Produces the PC-control inputs `int_nop`, `irq_ret` and redirect target; the top level muxes `pc_target` into the PC's `pc_new` whenever `irq_enter` or `irq_ret` is high.

Parameters:
- ISR_VECTOR, 32'h0000_0100, byte address of the ISR entry; word-aligned, must be below 4 KB.
- DRAIN_CYCLES, 2, number of `int_nop` cycles before the vector jump; range 1..15.
- SYNC_STAGES, 2, flip-flop depth of the `irq` synchronizer; minimum 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- irq  in  1  asynchronous external interrupt request; level input, rising edge is the event.
- pc  in  32  current fetch PC (the next instruction not yet fetched).
- jp_success  in  1  branch/jump taken this cycle.
- jp_target  in  32  target of that branch/jump.
- load_use  in  1  pipeline load-use stall active.
- eret_id  in  1  ERET instruction decoded this cycle.
- int_nop  out  1  hold the PC and inject a NOP into IF/ID.
- irq_enter  out  1  one-cycle pulse: load `pc_target` (the ISR vector) into the PC.
- irq_ret  out  1  one-cycle pulse: load `pc_target` (EPC) into the PC.
- pc_target  out  32  redirect address; ISR_VECTOR during `irq_enter`, EPC otherwise.
- epc  out  32  saved return address.
- in_isr  out  1  high from `irq_enter` up to and including the `irq_ret` cycle.

Behaviour:
- Reset (rst_n=0 at a clock edge, from any state):
  - state=IDLE; synchronizer, edge-detect flop, pending flag and drain counter cleared.
  - epc=0.
  - int_nop, irq_enter, irq_ret and in_isr are 0.
  - pc_target=0.
- Input conditioning:
  - `irq` passes through SYNC_STAGES flops, then a rising-edge detector.
  - A detected edge sets `pending`; further edges while pending are merged.
  - `pending` is cleared only on the ENTER transition.
- State machine (all outputs registered; one state per cycle):
  - IDLE:
    - Moves to DRAIN when `pending` && !jp_success && !load_use.
    - On that transition: epc<=pc; counter<=DRAIN_CYCLES-1; int_nop<=1.
    - If `jp_success` or `load_use` is high, the entry is deferred by a cycle; `pending` is held.
  - DRAIN:
    - int_nop=1.
    - If jp_success is asserted (an older branch resolving), epc<=jp_target. This is the last-writer rule: epc must equal the address the program would have fetched next.
    - Counter decrements each cycle; at 0, go to ENTER.
  - ENTER (1 cycle):
    - irq_enter=1; pc_target=ISR_VECTOR; int_nop=0; pending cleared.
    - Next state ISR.
  - ISR:
    - in_isr=1; no nesting.
    - New irq edges set `pending` but are not taken.
    - eret_id=1 -> RETURN.
  - RETURN (1 cycle):
    - irq_ret=1; pc_target=epc; in_isr=1.
    - Next state IDLE.
    - A pending interrupt may start DRAIN no earlier than the cycle after RETURN.
- Gating rules:
  - `eret_id` outside ISR is ignored; no `irq_ret` pulse.
  - `load_use` during DRAIN has no effect on the counter.
  - irq_enter and irq_ret are never high together.
- Entry latency:
  - Raw `irq` rising edge to `int_nop` high: SYNC_STAGES+2 cycles when unblocked (synchronizer, edge flop, IDLE decision).
  - int_nop high to irq_enter: DRAIN_CYCLES cycles.
- Widths: epc and pc_target are full 32 bits; the low 2 bits pass through unchanged; no arithmetic on addresses.

Decomposition:
- Shared package `irq_pkg`:
  - State enum: IDLE, DRAIN, ENTER, ISR, RETURN (3-bit encoding).
  - Default ISR_VECTOR constant.
- Sub-module `irq_sync_edge`: parameterised SYNC_STAGES synchronizer plus rising-edge pulse, with synchronous active-low reset. Reused for other async inputs.

Test Plan:
- Basic entry/return:
  - Stimulus: pc=0x040 steady; irq rises; later, eret_id pulse during ISR.
  - Response: int_nop high for 2 cycles starting 4 cycles after the edge; then irq_enter with pc_target=0x100; epc=0x040; on eret, irq_ret one cycle with pc_target=0x040; in_isr drops the following cycle.
- Branch blocking:
  - Stimulus: irq pending while jp_success=1 for 3 cycles (jp_target=0x080).
  - Response: no int_nop until the cycle after jp_success falls; epc = the then-current pc.
- Branch during drain:
  - Stimulus: DRAIN_CYCLES=2, epc=0x040; jp_success=1, jp_target=0x0A0 in the first DRAIN cycle.
  - Response: epc=0x0A0; on return, pc_target=0x0A0.
- Nested request:
  - Stimulus: irq edge while in ISR.
  - Response: no int_nop until after RETURN; new DRAIN begins 1 cycle after irq_ret; only one extra entry occurs even for 3 edges.
- Stray ERET:
  - Stimulus: eret_id in IDLE.
  - Response: irq_ret stays 0; state stays IDLE.
- Reset mid-drain:
  - Stimulus: rst_n=0 for 1 cycle during DRAIN.
  - Response: next cycle all outputs 0, epc=0; pending lost; no irq_enter follows.
